// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 encodings, FSM states, fault cause codes, legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    logic bad;
    if (we)
      bad = !(f3 inside {F3_B, F3_H, F3_W});
    else
      bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return bad;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension
// for loads; purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    unique case (1'b1)
      (st_size == 2'b00): begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      (st_size == 2'b01): begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (1'b1)
      (ld_funct3 == F3_B):
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      (ld_funct3 == F3_H):
        ld_data = {{16{shifted[15]}}, shifted[15:0]};
      (ld_funct3 == F3_BU):
        ld_data = {24'h0, shifted[7:0]};
      (ld_funct3 == F3_HU):
        ld_data = {16'h0, shifted[15:0]};
      default:
        ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: legality checks, bus FSM, timeout,
// core stall and load writeback.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_we,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_data_q;
  logic [CW-1:0]     cnt_q;
  logic              to_q;

  logic        illegal;
  logic        misal;
  logic        to_hit;
  logic        to_evt;
  logic        accept;
  logic        busy;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  assign illegal = f3_illegal(op_we, op_funct3);
  assign misal   = misaligned(op_funct3, op_addr[1:0]);
  assign to_hit  = (cnt_q == CW'(TIMEOUT - 1));
  assign busy    = (state_q == S_REQ) || (state_q == S_RESP);

  lsu_align u_align (
    .st_size   (op_funct3[1:0]),
    .st_off    (op_addr[1:0]),
    .st_data   (op_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_off    (addr_q[1:0]),
    .ld_rdata  (mem_rdata),
    .ld_data   (ld_ext)
  );

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    err       = 1'b0;
    err_cause = CAUSE_NONE;
    to_evt    = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (illegal) begin
            err       = 1'b1;
            err_cause = CAUSE_ILLEGAL;
          end else if (misal) begin
            err       = 1'b1;
            err_cause = CAUSE_MISALIGN;
          end else begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_gnt) begin
          state_d = we_q ? S_DONE : S_RESP;
        end else if (to_hit) begin
          state_d = S_DONE;
          to_evt  = 1'b1;
        end
      end
      S_RESP: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          state_d = S_DONE;
        end else if (to_hit) begin
          state_d = S_DONE;
          to_evt  = 1'b1;
        end
      end
      S_DONE: begin
        // op_valid is deliberately not sampled here
        if (to_q) begin
          err       = 1'b1;
          err_cause = CAUSE_TIMEOUT;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      ld_data_q <= 32'h0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= op_addr;
        we_q    <= op_we;
        f3_q    <= op_funct3;
        be_q    <= st_be;
        wdata_q <= st_wdata;
        cnt_q   <= '0;
        to_q    <= 1'b0;
      end else if (busy) begin
        cnt_q <= cnt_q + CW'(1);
        to_q  <= to_evt;
      end
      if (state_q == S_RESP && mem_rvalid)
        ld_data_q <= ld_ext;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ld_valid  = (state_q == S_DONE) && !we_q && !to_q;
  assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a load-data
// scoreboard and a TIMEOUT of 8.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_we = 1'b0;
  logic [2:0]  op_funct3 = 3'b000;
  logic [31:0] op_addr = 32'h0;
  logic [31:0] op_wdata = 32'h0;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic [1:0]  err_cause;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_we      (op_we),
    .op_funct3  (op_funct3),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .stall      (stall),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .err        (err),
    .err_cause  (err_cause),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          gnt_cyc,
    input logic [31:0] rdata,
    input logic [31:0] exp_ld,
    input logic [31:0] exp_maddr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input int          exp_stall
  );
    int stalls = 0;
    int req_cyc = 0;
    bit done = 0;
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_funct3 = f3;
    op_addr = addr; op_wdata = wd;
    #1;
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    if (stall) stalls++;
    if (!we) exp_q.push_back(exp_ld);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      op_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          chk({tag, "_maddr"}, mem_addr, exp_maddr);
          chk({tag, "_mwe"}, {31'h0, mem_we}, {31'h0, we});
          if (we) begin
            chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
          end
        end
        if (req_cyc == gnt_cyc) mem_gnt = 1'b1;
      end else if (stall) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      #1;
      if (stall) stalls++;
      else begin
        done = 1;
        chk({tag, "_done_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_done_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_ldv"}, {31'h0, ld_valid}, {31'h0, !we});
        if (ld_valid) begin
          if (exp_q.size() == 0)
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
          else
            chk({tag, "_ld_data"}, ld_data, exp_q.pop_front());
        end
      end
    end
    chk({tag, "_finished"}, {31'h0, done}, 32'h1);
    chk({tag, "_stall_cyc"}, stalls, exp_stall);
    @(negedge clk);
    #1;
    chk({tag, "_ldv_pulse"}, {31'h0, ld_valid}, 32'h0);
    chk({tag, "_idle_stall"}, {31'h0, stall}, 32'h0);
  endtask

  task automatic fault(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [1:0]  exp_cause
  );
    @(negedge clk);
    op_valid = 1'b1; op_we = we; op_funct3 = f3;
    op_addr = addr; op_wdata = 32'h1234_5678;
    #1;
    chk({tag, "_err"}, {31'h0, err}, 32'h1);
    chk({tag, "_cause"}, {30'h0, err_cause}, {30'h0, exp_cause});
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk({tag, "_no_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_err_clr"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    int stalls;
    bit done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_ldv", {31'h0, ld_valid}, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_cause", {30'h0, err_cause}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);

    access("sw", 1, F3_W, 32'h100, 32'hDEAD_BEEF, 3, 32'h0,
           32'h0, 32'h100, 4'b1111, 32'hDEAD_BEEF, 4);
    access("lb", 0, F3_B, 32'h103, 32'h0, 1, 32'h80FF_0000,
           32'hFFFF_FF80, 32'h100, 4'h0, 32'h0, 3);
    access("lbu", 0, F3_BU, 32'h103, 32'h0, 2, 32'h80FF_0000,
           32'h0000_0080, 32'h100, 4'h0, 32'h0, 4);
    access("lh", 0, F3_H, 32'h102, 32'h0, 1, 32'h8001_1234,
           32'hFFFF_8001, 32'h100, 4'h0, 32'h0, 3);
    access("lhu", 0, F3_HU, 32'h102, 32'h0, 1, 32'h8001_1234,
           32'h0000_8001, 32'h100, 4'h0, 32'h0, 3);
    access("lw", 0, F3_W, 32'h104, 32'h0, 1, 32'h1234_5678,
           32'h1234_5678, 32'h104, 4'h0, 32'h0, 3);
    access("sh", 1, F3_H, 32'h106, 32'h0000_ABCD, 1, 32'h0,
           32'h0, 32'h104, 4'b1100, 32'hABCD_ABCD, 2);
    access("sb", 1, F3_B, 32'h101, 32'h0000_0055, 1, 32'h0,
           32'h0, 32'h100, 4'b0010, 32'h5555_5555, 2);

    fault("lw_mis", 0, F3_W, 32'h101, CAUSE_MISALIGN);
    fault("lh_mis", 0, F3_H, 32'h103, CAUSE_MISALIGN);
    fault("ld_ill", 0, 3'b011, 32'h100, CAUSE_ILLEGAL);
    fault("ill_prio", 0, 3'b111, 32'h101, CAUSE_ILLEGAL);
    fault("st_ill", 1, F3_BU, 32'h100, CAUSE_ILLEGAL);

    // Granted load with no response runs out the timeout
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_funct3 = F3_W;
    op_addr = 32'h200;
    #1;
    stalls = stall ? 1 : 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      op_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (mem_req && c == 0) mem_gnt = 1'b1;
      #1;
      if (stall) stalls++;
      else begin
        done = 1;
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_cause", {30'h0, err_cause}, {30'h0, CAUSE_TIMEOUT});
        chk("to_ldv", {31'h0, ld_valid}, 32'h0);
        chk("to_ld_hold", ld_data, 32'h1234_5678);
        chk("to_req", {31'h0, mem_req}, 32'h0);
      end
    end
    chk("to_finished", {31'h0, done}, 32'h1);
    chk("to_stall_cyc", stalls, 9);
    @(negedge clk);
    #1;
    chk("to_err_clr", {31'h0, err}, 32'h0);

    // Reset while waiting for a load response
    @(negedge clk);
    op_valid = 1'b1; op_we = 1'b0; op_funct3 = F3_W;
    op_addr = 32'h300;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk("rr_req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rr_resp_req", {31'h0, mem_req}, 32'h0);
    chk("rr_resp_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("rr_stall", {31'h0, stall}, 32'h0);
    chk("rr_req_low", {31'h0, mem_req}, 32'h0);
    chk("rr_ldv", {31'h0, ld_valid}, 32'h0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rr_ldv2", {31'h0, ld_valid}, 32'h0);
    chk("rr_ld_data", ld_data, 32'h0);
    chk("rr_stall2", {31'h0, stall}, 32'h0);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU in the RISC-V core.
- Takes the ALU-computed effective address, funct3 and rs2 data for lb/lh/lw/lbu/lhu/sb/sh/sw.
- Drives a word-wide request/grant/response data-memory bus with byte enables.
- Returns aligned, sign/zero-extended load data to writeback and stalls the core (PC, regfile write) until the access completes.

Parameters:
- TIMEOUT, 255: max cycles spent in REQ+RESP before the access is aborted with a timeout error.
- ADDR_W, 32: address width (data width fixed at 32).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- op_valid  in  1  memory instruction present this cycle
- op_we  in  1  1=store, 0=load
- op_funct3  in  3  RISC-V funct3 of the load/store
- op_addr  in  ADDR_W  effective address from ALU
- op_wdata  in  32  rs2 store data
- stall  out  1  core must hold PC and suppress regfile write
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- err  out  1  access fault
- err_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3
- mem_req  out  1  bus request
- mem_gnt  in  1  request accepted this cycle
- mem_addr  out  ADDR_W  word-aligned address
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_rvalid  in  1  read response valid
- mem_rdata  in  32  read response word

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- On reset: state=IDLE, ld_data=0, ld_valid=0, err=0, err_cause=00, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- States: IDLE, REQ, RESP, DONE.
- IDLE, op_valid=1, legality checks:
  - Illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=00.
  - Illegal or misaligned: err=1 and err_cause combinationally in the same cycle, stall=0, no bus access, stay IDLE. Illegal takes priority over misaligned.
  - Legal: stall=1; latch addr, we, funct3 and steered wdata; go to REQ.
- REQ:
  - mem_req=1; mem_addr={addr[ADDR_W-1:2],2'b00}; mem_we, mem_be, mem_wdata held stable until grant.
  - On mem_gnt: a store goes to DONE (no response expected); a load goes to RESP.
  - mem_req drops on the cycle after gnt.
- RESP:
  - Wait for mem_rvalid; earliest is one cycle after gnt.
  - An rvalid arriving in REQ or IDLE is ignored.
  - On rvalid: register the extracted load into ld_data, go to DONE.
- DONE:
  - Exactly one cycle, stall=0. ld_valid=1 for a successful load.
  - op_valid is ignored here (the core advances its PC this cycle). Next state is IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments in REQ/RESP.
  - When the count reaches TIMEOUT: go to DONE with err=1, err_cause=10, ld_valid=0, ld_data unchanged, mem_req dropped.
- stall = (IDLE & op_valid & legal) | REQ | RESP.
- Store lanes:
  - sb: be=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - sh: be=addr[1]?1100:0011, wdata={2{d[15:0]}}.
  - sw: be=1111, wdata=d.
- Loads: shift rdata right by 8*addr[1:0], then lb/lh sign-extend and lbu/lhu zero-extend; lw passes the word through.
- ld_data holds its value until the next successful load.
- Reset mid-access: return to IDLE next edge, mem_req deasserted, any late rvalid ignored.

Decomposition:
- lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, err_cause codes.
- One combinational sub-module, lsu_align: store byte-enable/lane steering and load extraction/extension.
- FSM and timeout counter live in lsu_ctrl.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, gnt on 3rd REQ cycle:
  - mem_addr=0x100, be=1111, wdata=0xDEADBEEF.
  - stall high 4 cycles then low 1 cycle (DONE), no ld_valid.
- lb addr 0x103, rdata 0x80FF0000 -> ld_data=0xFFFFFF80, ld_valid 1 cycle; repeat as lbu -> 0x00000080.
- lh addr 0x102, rdata 0x80011234 -> 0xFFFF8001; lhu -> 0x00008001; lw addr 0x104, rdata 0x12345678 -> 0x12345678.
- sh addr 0x106, data 0x0000ABCD -> mem_addr 0x104, be 1100, wdata 0xABCDABCD; sb addr 0x101, data 0x55 -> be 0010, wdata 0x55555555.
- Faults:
  - lw addr 0x101 -> err=1, cause 01, stall 0, mem_req never rises.
  - load funct3 011 -> cause 11.
- Timeout and reset:
  - TIMEOUT=8, load granted, no rvalid -> err cause 10 in DONE after 8 counted cycles.
  - Separate run: rst asserted in RESP, then rvalid -> state IDLE, no ld_valid, ld_data=0.
